// File: rtl/jtframe_linedbl_pkg.sv
// Shared types and the per-channel scanline dimming rule for jtframe_linedbl.
package jtframe_linedbl_pkg;

   localparam int unsigned DIM_CW = 16;

   typedef enum logic [1:0] {DIM_OFF, DIM_75, DIM_50, DIM_BLK} dim_e;

   // Width-generic dimming; callers zero-extend to DIM_CW and truncate back.
   function automatic logic [DIM_CW-1:0] dim_ch(input logic [DIM_CW-1:0] c, input dim_e m);
      case (m)
         DIM_OFF: dim_ch = c;
         DIM_75:  dim_ch = c - (c >> 2);
         DIM_50:  dim_ch = c >> 1;
         default: dim_ch = '0;
      endcase
   endfunction

endpackage

// File: rtl/jtframe_linedbl_ram.sv
// Two-bank line buffer: one write port, one synchronous read port, addressed {bank, addr}.
module jtframe_linedbl_ram
   import jtframe_linedbl_pkg::*;
#(
   parameter int unsigned DW   = 12,
   parameter int unsigned HLEN = 384,
   parameter int unsigned AW   = 9
)(
   input  logic          clk,
   input  logic          we,
   input  logic          wr_bank,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_bank,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [2][HLEN];

   always_ff @(posedge clk) begin
      if (we) mem[wr_bank][wr_addr] <= wr_data;
      rd_data <= mem[rd_bank][rd_addr];
   end

endmodule

// File: rtl/jtframe_linedbl.sv
// Line doubler: stores each 15 kHz line and replays it twice at the x2 rate.
// Optional scanline dimming of the repeated line when JTFRAME_SCANLINES_EN is defined.
module jtframe_linedbl
   import jtframe_linedbl_pkg::*;
#(
   parameter int unsigned CW   = 4,
   parameter int unsigned CH   = 3,
   parameter int unsigned HLEN = 384,
   parameter int unsigned HSW  = 32
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             base_cen,
   input  logic             basex2_cen,
   input  logic [CW*CH-1:0] base_pxl,
   input  logic             HS,
   input  logic [1:0]       scanlines,
   output logic [CW*CH-1:0] x2_pxl,
   output logic             x2_HS
);

   localparam int unsigned   DW    = CW*CH;
   localparam int unsigned   AW    = $clog2(HLEN);
   localparam logic [AW-1:0] LAST  = AW'(HLEN-1);
   localparam logic [AW:0]   HSW_A = (AW+1)'(HSW);

   logic [AW-1:0] wr_addr, rd_addr, rd_d, wr_a;
   logic          wr_bank, wr_b, second, sec_d, hs_l, valid, hs_edge;
   logic [DW-1:0] rd_q, pxl_c;

   assign hs_edge = base_cen & HS & ~hs_l;
   // The write coinciding with the HS edge already targets the new bank at address 0.
   assign wr_a    = hs_edge ? '0 : wr_addr;
   assign wr_b    = hs_edge ? ~wr_bank : wr_bank;

   jtframe_linedbl_ram #(.DW(DW), .HLEN(HLEN), .AW(AW)) u_ram (
      .clk     (clk),
      .we      (base_cen & rst_n),
      .wr_bank (wr_b),
      .wr_addr (wr_a),
      .wr_data (base_pxl),
      .rd_bank (~wr_bank),
      .rd_addr (rd_addr),
      .rd_data (rd_q)
   );

`ifdef JTFRAME_SCANLINES_EN
   dim_e mode;

   function automatic logic [CW-1:0] dim_w(input logic [CW-1:0] c, input dim_e m);
      return CW'(dim_ch(DIM_CW'(c), m));
   endfunction

   always_comb begin
      pxl_c = rd_q;
      if (sec_d) begin
         for (int i = 0; i < int'(CH); i++)
            pxl_c[i*CW +: CW] = dim_w(rd_q[i*CW +: CW], mode);
      end
   end
`else
   logic unused_dim;
   assign unused_dim = ^{scanlines, sec_d};
   assign pxl_c      = rd_q;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_addr <= '0;
         wr_bank <= 1'b0;
         hs_l    <= 1'b0;
         rd_addr <= '0;
         second  <= 1'b0;
         valid   <= 1'b0;
         rd_d    <= '0;
         sec_d   <= 1'b0;
         x2_pxl  <= '0;
         x2_HS   <= 1'b0;
`ifdef JTFRAME_SCANLINES_EN
         mode    <= DIM_OFF;
`endif
      end else begin
         if (base_cen) begin
            hs_l    <= HS;
            wr_bank <= wr_b;
            wr_addr <= (wr_a == LAST) ? LAST : wr_a + AW'(1);
         end
         // HS edge outranks a simultaneous read wrap.
         if (hs_edge) begin
            rd_addr <= '0;
            second  <= 1'b0;
            valid   <= 1'b1;
`ifdef JTFRAME_SCANLINES_EN
            mode    <= dim_e'(scanlines);
`endif
         end else if (basex2_cen) begin
            if (rd_addr == LAST) begin
               rd_addr <= '0;
               second  <= ~second;
            end else begin
               rd_addr <= rd_addr + AW'(1);
            end
         end
         rd_d  <= rd_addr;
         sec_d <= second;
         if (basex2_cen) begin
            x2_pxl <= valid ? pxl_c : '0;
            x2_HS  <= valid && ({1'b0, rd_d} < HSW_A);
         end
      end
   end

endmodule

// File: tb/tb_jtframe_linedbl.sv
// Randomised bench for jtframe_linedbl against a line-level behavioural model.
module tb_jtframe_linedbl;

   localparam int CW = 4, CH = 3, DW = 12, HLEN = 384, HSW = 32;
   localparam int NEP = 32, NIDX = 4*2*HLEN;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          base_cen = 1'b0, basex2_cen = 1'b0, HS = 1'b0;
   logic [DW-1:0] base_pxl = '0;
   logic [1:0]    scanlines = 2'd0;
   logic [DW-1:0] x2_pxl;
   logic          x2_HS;

   jtframe_linedbl #(.CW(CW), .CH(CH), .HLEN(HLEN), .HSW(HSW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .base_cen   (base_cen),
      .basex2_cen (basex2_cen),
      .base_pxl   (base_pxl),
      .HS         (HS),
      .scanlines  (scanlines),
      .x2_pxl     (x2_pxl),
      .x2_HS      (x2_HS)
   );

   always #10 clk = ~clk;

   typedef struct {
      logic [DW-1:0] pxl;
      logic          hs;
      int            ep;
      int            idx;
   } exp_t;

   exp_t          exp_q[$];
   int            vectors = 0, fails = 0;
   int            phase = 0;
   int            cap_p [NEP][NIDX];
   logic          cap_h [NEP][NIDX];

   // Model: the line being written, the line on display, and position within the display period.
   logic [DW-1:0] cur   [HLEN];
   logic [DW-1:0] shown [HLEN];
   logic [DW-1:0] line_px [400];
   int            m_wr = 0, m_pos = 0, m_pass = 0, m_mode = 0, epoch = 0;
   bit            m_valid = 0, m_hsl = 0;

   function automatic logic [DW-1:0] dim_pix(input logic [DW-1:0] p, input int mode);
      logic [DW-1:0] r;
      int c;
      r = p;
`ifdef JTFRAME_SCANLINES_EN
      for (int k = 0; k < CH; k++) begin
         c = int'(p[k*CW +: CW]);
         case (mode)
            1: c = c - c/4;
            2: c = c/2;
            3: c = 0;
            default: ;
         endcase
         r[k*CW +: CW] = 4'(c);
      end
`else
      c = mode;
`endif
      return r;
   endfunction

   task automatic model_edge();
      exp_t e;
      if (!rst_n) begin
         m_valid = 0; m_pos = 0; m_pass = 0; m_wr = 0; m_hsl = 0; m_mode = 0;
      end else if (base_cen) begin
         if (HS && !m_hsl) begin
            shown = cur;
            m_wr = 0; m_pos = 0; m_pass = 0; m_valid = 1;
            m_mode = int'(scanlines);
            epoch++;
         end
         cur[m_wr] = base_pxl;
         if (m_wr < HLEN-1) m_wr++;
         m_hsl = HS;
      end
      if (basex2_cen) begin
         e.ep = epoch; e.idx = m_pass*HLEN + m_pos;
         if (!rst_n || !m_valid) begin
            e.pxl = '0; e.hs = 1'b0;
         end else begin
            e.pxl = (m_pass % 2 == 1) ? dim_pix(shown[m_pos], m_mode) : shown[m_pos];
            e.hs  = (m_pos < HSW);
         end
         exp_q.push_back(e);
         if (rst_n) begin
            m_pos++;
            if (m_pos == HLEN) begin m_pos = 0; m_pass++; end
         end
      end
   endtask

   task automatic clk_step(input logic [DW-1:0] p, input logic h);
      @(negedge clk);
      phase++;
      base_cen   = (phase % 8) == 0;
      basex2_cen = (phase % 4) == 2;
      base_pxl   = p;
      HS         = h;
      model_edge();
   endtask

   task automatic push_pixel(input logic [DW-1:0] p, input logic h);
      do clk_step(p, h); while (!base_cen);
   endtask

   // kind: 0 random (with a mid-line scanlines change), 1 ramp, 2 constant val
   task automatic send_line(input int npix, input bit hs_on, input int kind,
                            input logic [DW-1:0] val, output int ep);
      logic [DW-1:0] p;
      ep = -1;
      for (int i = 0; i < npix; i++) begin
         case (kind)
            0:       p = 12'($urandom);
            1:       p = 12'(i);
            default: p = val;
         endcase
         if (i < 400) line_px[i] = p;
         push_pixel(p, hs_on && (i < 16));
         if (i == 0) ep = epoch;
         if (kind == 0 && i == npix/2) scanlines = 2'($urandom);
      end
   endtask

   task automatic lit(input string name, input int got, input int want);
      vectors++;
      if (got != want) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, got, want);
      end
   endtask

   // Compare every x2 tick against the model.
   always @(posedge clk) begin
      if (basex2_cen) begin
         exp_t e;
         #1;
         vectors++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL tick_queue: no expectation, got pxl %h hs %b", x2_pxl, x2_HS);
         end else begin
            e = exp_q.pop_front();
            if (x2_pxl !== e.pxl || x2_HS !== e.hs) begin
               fails++;
               $display("FAIL tick ep%0d idx%0d: got pxl %h hs %b, expected pxl %h hs %b",
                        e.ep, e.idx, x2_pxl, x2_HS, e.pxl, e.hs);
            end
            if (e.ep >= 0 && e.ep < NEP && e.idx < NIDX) begin
               cap_p[e.ep][e.idx] = int'(x2_pxl);
               cap_h[e.ep][e.idx] = x2_HS;
            end
         end
      end
   end

   initial begin
      int ep0, e_f1, e_f2, e_f3, e_f4, e_p, e_a, e_e, e_l, e_m, e_x;
      int a_pix7, d_last;
      for (int i = 0; i < NEP; i++)
         for (int j = 0; j < NIDX; j++) begin cap_p[i][j] = -1; cap_h[i][j] = 1'bx; end
      for (int i = 0; i < HLEN; i++) begin cur[i] = '0; shown[i] = '0; end

      rst_n = 1'b0;
      for (int i = 0; i < 5; i++) clk_step('0, 1'b0);
      @(posedge clk); #1;
      lit("reset_pxl", int'(x2_pxl), 0);
      lit("reset_hs", int'(x2_HS), 0);
      rst_n = 1'b1;

      send_line(HLEN, 1'b0, 0, '0, ep0);
      lit("pre_hs_pxl", int'(x2_pxl), 0);
      scanlines = 2'd0;
      send_line(HLEN, 1'b1, 1, '0, ep0);           // ramp
      scanlines = 2'd0;
      send_line(HLEN, 1'b1, 2, 12'hFFF, e_f1);     // shows ramp
      scanlines = 2'd1;
      send_line(HLEN, 1'b1, 2, 12'hFFF, e_f2);
      scanlines = 2'd2;
      send_line(HLEN, 1'b1, 2, 12'hFFF, e_f3);
      scanlines = 2'd3;
      send_line(HLEN, 1'b1, 2, 12'hFFF, e_f4);
      scanlines = 2'd0;
      send_line(HLEN, 1'b1, 2, 12'h5A3, e_p);
      scanlines = 2'd0;
      send_line(HLEN, 1'b1, 0, '0, e_a);           // A, then 3 lines without HS
      a_pix7 = int'(line_px[7]);
      send_line(HLEN, 1'b0, 0, '0, ep0);
      send_line(HLEN, 1'b0, 0, '0, ep0);
      send_line(HLEN, 1'b0, 0, '0, ep0);
      d_last = int'(line_px[HLEN-1]);
      send_line(HLEN, 1'b1, 0, '0, e_e);
      scanlines = 2'd0;
      send_line(400, 1'b1, 1, '0, e_l);            // overlong ramp
      scanlines = 2'd0;
      send_line(HLEN, 1'b1, 0, '0, e_m);
      for (int n = 0; n < 5; n++) send_line(HLEN, 1'b1, 0, '0, e_x);

      send_line(100, 1'b1, 0, '0, e_x);            // display now near rd_addr 200
      rst_n = 1'b0;
      clk_step('0, 1'b0);
      @(posedge clk); #1;
      lit("midreset_pxl", int'(x2_pxl), 0);
      lit("midreset_hs", int'(x2_HS), 0);
      clk_step('0, 1'b0);
      rst_n = 1'b1;
      send_line(HLEN, 1'b0, 0, '0, e_x);
      send_line(HLEN, 1'b1, 0, '0, e_x);
      send_line(HLEN, 1'b1, 0, '0, e_x);
      for (int i = 0; i < 16; i++) clk_step('0, 1'b0);
      @(posedge clk); #2;

      lit("ramp_first0",    cap_p[e_f1][0], 0);
      lit("ramp_first200",  cap_p[e_f1][200], 200);
      lit("ramp_first383",  cap_p[e_f1][383], 383);
      lit("ramp_second0",   cap_p[e_f1][384], 0);
      lit("ramp_second383", cap_p[e_f1][767], 383);
      lit("hs_tick0",   int'(cap_h[e_f1][0]), 1);
      lit("hs_tick31",  int'(cap_h[e_f1][31]), 1);
      lit("hs_tick32",  int'(cap_h[e_f1][32]), 0);
      lit("hs_tick384", int'(cap_h[e_f1][384]), 1);
      lit("hs_tick415", int'(cap_h[e_f1][415]), 1);
      lit("hs_tick416", int'(cap_h[e_f1][416]), 0);
      lit("dim_first",  cap_p[e_f2][10], 12'hFFF);
`ifdef JTFRAME_SCANLINES_EN
      lit("dim_75", cap_p[e_f2][394], 12'hCCC);
      lit("dim_50", cap_p[e_f3][394], 12'h777);
      lit("dim_blk", cap_p[e_f4][394], 12'h000);
`else
      lit("dim_75", cap_p[e_f2][394], 12'hFFF);
      lit("dim_50", cap_p[e_f3][394], 12'hFFF);
      lit("dim_blk", cap_p[e_f4][394], 12'hFFF);
`endif
      lit("nohs_repeat6", cap_p[e_a][3*2*HLEN + 100], 12'h5A3);
      lit("nohs_repeat8", cap_p[e_a][7*HLEN + 383], 12'h5A3);
      lit("nohs_resume7",  cap_p[e_e][7], a_pix7);
      lit("nohs_resume383", cap_p[e_e][383], d_last);
      lit("long_addr0",   cap_p[e_m][0], 0);
      lit("long_addr382", cap_p[e_m][382], 382);
      lit("long_addr383", cap_p[e_m][383], 399);
      lit("long_second383", cap_p[e_m][767], 399);
      lit("epochs_seen", e_p, 6);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
